sel_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: sel_4_1_rr_arbiter
// PURPOSE
//   Shares one 4-to-1 selector datapath among four requesters. Arbitrates REQ[3:0], drives the
//   selector's 2-bit SEL code and a one-hot GNT back to the requesters, and holds the grant
//   while the owner keeps requesting. Enforces a bounded hold time when other requesters wait,
//   and inserts one idle cycle between owners so the selector output settles.
// PARAMETERS
//   MAX_HOLD  16  max consecutive GNT cycles for one owner while others wait; legal 2..255
//   CNT_W     8   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   CLK      in   1   single clock, all state updates on rising edge
//   RST      in   1   synchronous, active-high reset
//   REQ      in   4   request per source; REQ[i] maps to selector input i (0=A,1=B,2=C,3=D)
//   GNT      out  4   one-hot grant, registered; all-zero when no owner
//   SEL      out  2   selector code = index of current/last owner, registered
//   VALID    out  1   1 while GNT is non-zero (selector output belongs to an owner)
//   PREEMPT  out  1   1-cycle pulse: current grant ended by MAX_HOLD timeout
// BEHAVIOUR
//   - Reset (RST=1 at edge): GNT=0, SEL=2'b00, VALID=0, PREEMPT=0, hold count=0,
//     round-robin pointer LAST=3 (so REQ[0] wins first), state=IDLE. RST overrides all inputs.
//   - States: IDLE, GRANT.
//   - IDLE: if REQ!=0, choose winner W, next edge: GNT=1<<W, SEL=W, VALID=1, count=1,
//     state=GRANT. REQ->GNT latency = 1 cycle. If REQ==0, remain IDLE, outputs GNT=0/VALID=0,
//     SEL keeps last value.
//   - Winner (round-robin): first asserted REQ scanning LAST+1, LAST+2, ... modulo 4 (wraps 3->0).
//     LAST updates to W when grant is issued.
//   - GRANT, owner O:
//     * REQ[O]=0 -> next edge: GNT=0, VALID=0, state=IDLE (release; count cleared).
//     * REQ[O]=1 and count==MAX_HOLD and (REQ & ~(1<<O))!=0 -> next edge: GNT=0, VALID=0,
//       PREEMPT=1 for that one cycle, state=IDLE.
//     * REQ[O]=1 and count==MAX_HOLD and no other request -> keep grant; count saturates.
//     * otherwise keep grant; count increments.
//   - Release and preemption both leave exactly one idle cycle (GNT=0) before the next grant;
//     the next grant is decided in that IDLE cycle from the REQ sampled there.
//   - Requests from non-owners during GRANT are ignored until IDLE; no queuing.
//   - Owner dropping REQ on the same cycle the timeout fires -> normal release, PREEMPT=0.
//   - GNT is always one-hot or zero; SEL never changes while VALID=1.
//   - Reset mid-grant: next edge returns to reset values; no PREEMPT pulse.
// CONFIGURATION
//   SEL_ARB_FIXED_PRIO_EN
//     defined:   winner = lowest asserted REQ index (0 highest); LAST pointer unused;
//                MAX_HOLD timeout still applies.
//     undefined: round-robin as above (default build).
// TESTING
//   1 Reset: RST=1 two cycles, REQ=4'hF -> GNT=0, SEL=0, VALID=0, PREEMPT=0 throughout.
//   2 Single req: REQ=4'b0100 from cycle 0 -> cycle 1 GNT=4'b0100, SEL=2, VALID=1; drop REQ at
//     cycle 5 -> cycle 6 GNT=0, VALID=0, SEL stays 2.
//   3 Round-robin: REQ=4'hF, each owner drops REQ 3 cycles after grant then re-raises ->
//     grant order 0,1,2,3,0 with one idle cycle between each; wrap 3->0 checked.
//   4 Timeout: MAX_HOLD=4, REQ[1] held, REQ[3] raised at cycle 2 -> GNT[1] for 4 cycles,
//     PREEMPT=1 with GNT=0 next cycle, then GNT=4'b1000, SEL=3.
//   5 Sole owner: MAX_HOLD=4, only REQ[2] held 20 cycles -> GNT=4'b0100 continuous, PREEMPT=0.
//   6 Fixed prio (SEL_ARB_FIXED_PRIO_EN): REQ=4'b1010 repeatedly released/re-raised ->
//     owner always 1; without macro owners alternate 1,3.

Source files
------------

// File: rtl/sel_4_1_rr_arbiter.sv
// sel_4_1_rr_arbiter
//   Arbitrates four requesters sharing one 4-to-1 selector datapath. The winner
//   owns the selector until it drops its request or, while another requester is
//   waiting, until it has held the grant for MAX_HOLD consecutive cycles. Every
//   change of owner passes through one idle cycle (gnt=0) so the selector output
//   can settle before the next owner sees it.
//
// Configuration macro:
//   SEL_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest request index wins
//                          undefined -> round-robin starting after the last owner
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles for one owner while others wait (2..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      request per source, req[i] drives selector input i
//   gnt      registered one-hot grant, zero when no owner
//   sel      registered selector code, index of current/last owner
//   valid    1 while gnt is non-zero
//   preempt  1-cycle pulse when a grant is ended by the hold timeout

module sel_4_1_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       winner;
  logic             others_wait;

  // gnt is one-hot on the owner, so masking req with ~gnt leaves only waiters.
  assign others_wait = |(req & ~gnt);

`ifdef SEL_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downward lets index 0 overwrite last.
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`else
  logic [1:0] last;

  // Scan last+4 (== last) down to last+1 so the nearest request after the
  // previous owner is the final assignment and therefore the winner.
  always_comb begin
    winner = last;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) winner = last + 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      valid   <= 1'b0;
      preempt <= 1'b0;
      cnt     <= '0;
`ifndef SEL_ARB_FIXED_PRIO_EN
      last    <= 2'd3;
`endif
    end else begin
      case (state)
        IDLE: begin
          preempt <= 1'b0;
          if (|req) begin
            state <= GRANT;
            gnt   <= 4'(1) << winner;
            sel   <= winner;
            valid <= 1'b1;
            cnt   <= CNT_W'(1);
`ifndef SEL_ARB_FIXED_PRIO_EN
            last  <= winner;
`endif
          end else begin
            gnt   <= 4'b0000;
            valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            // Owner released; a release on the timeout cycle is not a preemption.
            state   <= IDLE;
            gnt     <= 4'b0000;
            valid   <= 1'b0;
            cnt     <= '0;
            preempt <= 1'b0;
          end else if (cnt == HOLD_MAX && others_wait) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            valid   <= 1'b0;
            cnt     <= '0;
            preempt <= 1'b1;
          end else begin
            // Sole requester keeps the grant indefinitely; counter saturates.
            preempt <= 1'b0;
            if (cnt != HOLD_MAX) cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_4_1_rr_arbiter.sv
module tb_sel_4_1_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       preempt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 = none), cycles held, last winner.
  int         m_owner;
  int         m_held;
  int         m_last;
  logic [1:0] m_sel;
  logic       m_pre;

  always #5 clk = ~clk;

  sel_4_1_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
    .valid(valid), .preempt(preempt)
  );

  function automatic int pick(input logic [3:0] r, input int lst);
`ifdef SEL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(lst + k) % 4]) return (lst + k) % 4;
`endif
    return -1;
  endfunction

  function automatic logic [7:0] expv();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, m_sel, (m_owner >= 0), m_pre};
  endfunction

  // Advance one clock: the model consumes the same rst/req the DUT samples.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 2'd0; m_pre = 1'b0;
    end else if (m_owner < 0) begin
      m_pre = 1'b0;
      if (req != 4'b0000) begin
        m_owner = pick(req, m_last);
        m_last  = m_owner;
        m_sel   = 2'(m_owner);
        m_held  = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_held = 0; m_pre = 1'b0;
    end else if (m_held >= MAXH && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
      m_owner = -1; m_held = 0; m_pre = 1'b1;
    end else begin
      m_pre = 1'b0;
      if (m_held < MAXH) m_held++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== 8'b0) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, 8'b0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 5) req = 4'b0000;
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== expv()) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
      if (c == 1) begin
        n_cmp++;
        if ({gnt, sel, valid} !== {4'b0100, 2'd2, 1'b1}) begin
          n_bad++;
          $display("FAIL single_grant got=%b required=%b", {gnt, sel, valid}, {4'b0100, 2'd2, 1'b1});
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({gnt, sel, valid} !== {4'b0000, 2'd2, 1'b0}) begin
          n_bad++;
          $display("FAIL single_release got=%b required=%b", {gnt, sel, valid}, {4'b0000, 2'd2, 1'b0});
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int   q[$];
    int   exp_q[5];
    logic prevv;
`ifdef SEL_ARB_FIXED_PRIO_EN
    exp_q = '{0, 0, 0, 0, 0};
`else
    exp_q = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    prevv = 1'b0;
    req = 4'hF;
    for (int c = 0; c < 60 && q.size() < 5; c++) begin
      step();
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== expv()) begin
        n_bad++;
        $display("FAIL rr cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
      if (valid && !prevv) q.push_back(int'(sel));
      prevv = valid;
      req = 4'hF;
      if (m_owner >= 0 && m_held == 3) req[m_owner] = 1'b0;
    end
    n_cmp++;
    if (q.size() != 5) begin
      n_bad++;
      $display("FAIL rr_count got=%0d required=5", q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (q[i] != exp_q[i]) begin
          n_bad++;
          $display("FAIL rr_order idx=%0d got=%0d required=%0d", i, q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int         n1;
    logic [7:0] v5, v6;
    logic [5:0] exp6;
`ifdef SEL_ARB_FIXED_PRIO_EN
    exp6 = {4'b0010, 2'd1};
`else
    exp6 = {4'b1000, 2'd3};
`endif
    do_reset();
    n1 = 0; v5 = '0; v6 = '0;
    req = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 2) req[3] = 1'b1;
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== expv()) begin
        n_bad++;
        $display("FAIL timeout cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
      if (c <= 5 && gnt == 4'b0010) n1++;
      if (c == 5) v5 = {gnt, sel, valid, preempt};
      if (c == 6) v6 = {gnt, sel, valid, preempt};
    end
    n_cmp++;
    if (n1 != MAXH) begin
      n_bad++;
      $display("FAIL timeout_hold got=%0d required=%0d", n1, MAXH);
    end
    n_cmp++;
    if ({v5[7:4], v5[1:0]} !== {4'b0000, 2'b01}) begin
      n_bad++;
      $display("FAIL timeout_preempt got=%b required=%b", {v5[7:4], v5[1:0]}, {4'b0000, 2'b01});
    end
    n_cmp++;
    if (v6[7:2] !== exp6) begin
      n_bad++;
      $display("FAIL timeout_next got=%b required=%b", v6[7:2], exp6);
    end
  endtask

  task automatic test_sole_owner();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_cmp++;
      if ({gnt, preempt} !== {4'b0100, 1'b0} || {gnt, sel, valid, preempt} !== expv()) begin
        n_bad++;
        $display("FAIL sole cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
    end
  endtask

  task automatic test_fixed_prio();
    int   q[$];
    int   exp_q[4];
    logic prevv;
`ifdef SEL_ARB_FIXED_PRIO_EN
    exp_q = '{1, 1, 1, 1};
`else
    exp_q = '{1, 3, 1, 3};
`endif
    do_reset();
    prevv = 1'b0;
    req = 4'b1010;
    for (int c = 0; c < 60 && q.size() < 4; c++) begin
      step();
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== expv()) begin
        n_bad++;
        $display("FAIL prio cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
      if (valid && !prevv) q.push_back(int'(sel));
      prevv = valid;
      req = 4'b1010;
      if (m_owner >= 0 && m_held == 2) req[m_owner] = 1'b0;
    end
    n_cmp++;
    if (q.size() != 4) begin
      n_bad++;
      $display("FAIL prio_count got=%0d required=4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (q[i] != exp_q[i]) begin
          n_bad++;
          $display("FAIL prio_order idx=%0d got=%0d required=%0d", i, q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom);
      // Owner usually keeps requesting so timeouts and saturation occur often.
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      req = r;
      rst = ($urandom_range(0, 59) == 0);
      step();
      n_cmp++;
      if ({gnt, sel, valid, preempt} !== expv() || $countones(gnt) > 1) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b required=%b", c, {gnt, sel, valid, preempt}, expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    m_owner = -1; m_held = 0; m_last = 3; m_sel = 2'd0; m_pre = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_sole_owner();
    test_fixed_prio();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
